// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, with
// request/ack sequencing, timeout recovery, branch-flush discard and stalls.
module mem_port_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        mem_req,
  input  logic        mem_rw,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        port_req,
  output logic        port_rw,
  output logic [1:0]  port_size,
  output logic [31:0] port_addr,
  output logic [31:0] port_wdata,
  input  logic        port_ack,
  input  logic [31:0] port_rdata,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, RESP} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_q;
  logic        owner_mem_q;
  logic        flushed_q;
  logic        resp_if_q;
  logic        resp_mem_q;
  logic        timeout_q;
  logic        port_req_q;
  logic        port_rw_q;
  logic [1:0]  port_size_q;
  logic [7:0]  wait_q;
  logic [7:0]  wait_d;
  logic [31:0] port_addr_q;
  logic [31:0] port_wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] mem_rdata_q;
  logic        expire;
  logic [31:0] resp_data;

  assign wait_d    = wait_q + 8'd1;
  // A cycle with ack always wins over an expiring counter.
  assign expire    = ~port_ack & (wait_d == TIMEOUT_CNT);
  assign resp_data = port_ack ? port_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_mem_q  <= 1'b0;
      flushed_q    <= 1'b0;
      resp_if_q    <= 1'b0;
      resp_mem_q   <= 1'b0;
      timeout_q    <= 1'b0;
      port_req_q   <= 1'b0;
      port_rw_q    <= 1'b0;
      port_size_q  <= 2'b00;
      wait_q       <= 8'd0;
      port_addr_q  <= 32'h0;
      port_wdata_q <= 32'h0;
      if_rdata_q   <= 32'h0;
      mem_rdata_q  <= 32'h0;
    end else begin
      resp_if_q  <= 1'b0;
      resp_mem_q <= 1'b0;
      case (state_q)
        IDLE: begin
          wait_q <= 8'd0;
          if (mem_req) begin
            state_q      <= BUSY_MEM;
            owner_mem_q  <= 1'b1;
            port_req_q   <= 1'b1;
            port_rw_q    <= mem_rw;
            port_size_q  <= mem_size;
            port_addr_q  <= mem_addr;
            port_wdata_q <= mem_wdata;
          end else if (if_req && !if_flush) begin
            state_q      <= BUSY_IF;
            owner_mem_q  <= 1'b0;
            port_req_q   <= 1'b1;
            port_rw_q    <= 1'b0;
            port_size_q  <= 2'b10;
            port_addr_q  <= if_addr;
            port_wdata_q <= 32'h0;
          end
        end
        BUSY_IF, BUSY_MEM: begin
          // A fetch cannot be aborted on the port, only its result dropped.
          if (state_q == BUSY_IF && if_flush) flushed_q <= 1'b1;
          if (port_ack || expire) begin
            state_q    <= RESP;
            port_req_q <= 1'b0;
            if (!port_ack) timeout_q <= 1'b1;
            if (owner_mem_q) begin
              mem_rdata_q <= resp_data;
              resp_mem_q  <= 1'b1;
            end else begin
              if_rdata_q <= resp_data;
              resp_if_q  <= 1'b1;
            end
          end else begin
            wait_q <= wait_d;
          end
        end
        RESP: begin
          state_q   <= IDLE;
          flushed_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign port_req    = port_req_q;
  assign port_rw     = port_rw_q;
  assign port_size   = port_size_q;
  assign port_addr   = port_addr_q;
  assign port_wdata  = port_wdata_q;
  assign mem_rdata   = mem_rdata_q;
  assign if_rdata    = if_rdata_q;
  assign timeout_err = timeout_q;
  assign mem_done    = resp_mem_q;
  assign if_valid    = resp_if_q & ~flushed_q & ~if_flush;
  assign stall_mem   = mem_req & ~mem_done;
  assign stall_if    = stall_mem | (if_req & ~if_valid & ~if_flush);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cycle tables plus randomized traffic
// checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush, mem_req, mem_rw, port_ack;
  logic [1:0]  mem_size;
  logic [31:0] if_addr, mem_addr, mem_wdata, port_rdata;
  logic [31:0] if_rdata, mem_rdata, port_addr, port_wdata;
  logic        if_valid, mem_done, stall_if, stall_mem, port_req, port_rw, timeout_err;
  logic [1:0]  port_size;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .port_req(port_req), .port_rw(port_rw), .port_size(port_size),
    .port_addr(port_addr), .port_wdata(port_wdata),
    .port_ack(port_ack), .port_rdata(port_rdata),
    .timeout_err(timeout_err)
  );

  typedef struct {
    bit        rst;
    bit        mreq;
    bit        mrw;
    bit [1:0]  msz;
    bit [31:0] maddr;
    bit [31:0] mwd;
    bit        ireq;
    bit        ifl;
    bit [31:0] iaddr;
    bit        ack;
    bit [31:0] rd;
    bit [4:0]  exp;   // {port_req, mem_done, if_valid, stall_mem, stall_if}
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit rst, bit mreq, bit mrw, bit [1:0] msz, bit [31:0] maddr,
                             bit [31:0] mwd, bit ireq, bit ifl, bit [31:0] iaddr,
                             bit ack, bit [31:0] rd, bit [4:0] exp);
    vec_t r;
    r.rst = rst; r.mreq = mreq; r.mrw = mrw; r.msz = msz; r.maddr = maddr;
    r.mwd = mwd; r.ireq = ireq; r.ifl = ifl; r.iaddr = iaddr;
    r.ack = ack; r.rd = rd; r.exp = exp;
    return r;
  endfunction

  // Reference model: one outstanding transaction described by its owner,
  // latched request fields, cycles waited and whether it is in its response cycle.
  bit        m_busy, m_own_mem, m_resp, m_resp_mem, m_fl, m_terr, m_rw;
  bit [1:0]  m_sz;
  int        m_wait;
  bit [31:0] m_addr, m_wd, m_ird, m_mrd;

  task automatic model_clear();
    m_busy = 0; m_own_mem = 0; m_resp = 0; m_resp_mem = 0; m_fl = 0; m_terr = 0;
    m_rw = 0; m_sz = 0; m_wait = 0; m_addr = 0; m_wd = 0; m_ird = 0; m_mrd = 0;
  endtask

  task automatic model_finish(input bit [31:0] d);
    if (m_own_mem) m_mrd = d; else m_ird = d;
    m_busy = 0;
    m_resp = 1;
    m_resp_mem = m_own_mem;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_clear();
    end else if (m_resp) begin
      m_resp = 0;
      m_fl = 0;
    end else if (m_busy) begin
      if (!m_own_mem && if_flush) m_fl = 1;
      if (port_ack) model_finish(port_rdata);
      else begin
        m_wait++;
        if (m_wait == TO) begin
          m_terr = 1;
          model_finish(32'h0);
        end
      end
    end else if (mem_req) begin
      m_busy = 1; m_own_mem = 1; m_wait = 0;
      m_rw = mem_rw; m_sz = mem_size; m_addr = mem_addr; m_wd = mem_wdata;
    end else if (if_req && !if_flush) begin
      m_busy = 1; m_own_mem = 0; m_wait = 0;
      m_rw = 0; m_sz = 2'b10; m_addr = if_addr;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    bit e_md, e_iv, e_sm, e_si;
    e_md = m_resp && m_resp_mem;
    e_iv = m_resp && !m_resp_mem && !m_fl && !if_flush;
    e_sm = mem_req && !e_md;
    e_si = e_sm || (if_req && !e_iv && !if_flush);
    chk("port_req", {31'b0, port_req}, {31'b0, m_busy});
    chk("mem_done", {31'b0, mem_done}, {31'b0, e_md});
    chk("if_valid", {31'b0, if_valid}, {31'b0, e_iv});
    chk("stall_mem", {31'b0, stall_mem}, {31'b0, e_sm});
    chk("stall_if", {31'b0, stall_if}, {31'b0, e_si});
    chk("timeout_err", {31'b0, timeout_err}, {31'b0, m_terr});
    chk("mem_rdata", mem_rdata, m_mrd);
    if (e_iv) chk("if_rdata", if_rdata, m_ird);
    if (m_busy) begin
      chk("port_addr", port_addr, m_addr);
      chk("port_rw", {31'b0, port_rw}, {31'b0, m_rw});
      chk("port_size", {30'b0, port_size}, {30'b0, m_sz});
      if (m_own_mem) chk("port_wdata", port_wdata, m_wd);
    end
  endtask

  // Called just after a rising edge; checks mid-cycle, then advances one cycle.
  task automatic step(input vec_t r, input bit use_exp);
    reset = r.rst; mem_req = r.mreq; mem_rw = r.mrw; mem_size = r.msz;
    mem_addr = r.maddr; mem_wdata = r.mwd; if_req = r.ireq; if_flush = r.ifl;
    if_addr = r.iaddr; port_ack = r.ack; port_rdata = r.rd;
    @(negedge clk);
    model_check();
    if (use_exp) begin
      chk("tbl_port_req", {31'b0, port_req}, {31'b0, r.exp[4]});
      chk("tbl_mem_done", {31'b0, mem_done}, {31'b0, r.exp[3]});
      chk("tbl_if_valid", {31'b0, if_valid}, {31'b0, r.exp[2]});
      chk("tbl_stall_mem", {31'b0, stall_mem}, {31'b0, r.exp[1]});
      chk("tbl_stall_if", {31'b0, stall_if}, {31'b0, r.exp[0]});
    end
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t r;
    reset = 1; if_req = 0; if_flush = 0; mem_req = 0; mem_rw = 0; port_ack = 0;
    mem_size = 0; if_addr = 0; mem_addr = 0; mem_wdata = 0; port_rdata = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    chk("rst_port_req", {31'b0, port_req}, 32'h0);
    chk("rst_port_rw", {31'b0, port_rw}, 32'h0);
    chk("rst_port_size", {30'b0, port_size}, 32'h0);
    chk("rst_port_addr", port_addr, 32'h0);
    chk("rst_port_wdata", port_wdata, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_done_valid", {30'b0, mem_done, if_valid}, 32'h0);
    chk("rst_timeout_err", {31'b0, timeout_err}, 32'h0);
    model_edge();
    @(posedge clk);
    #1;

    // Load with ack in the first busy cycle
    tbl.push_back(v(0,1,0,2'b10,32'h40,0, 0,0,0, 0,0,           5'b00011));
    tbl.push_back(v(0,1,0,2'b10,32'h40,0, 0,0,0, 1,32'hDEADBEEF,5'b10011));
    tbl.push_back(v(0,1,0,2'b10,32'h40,0, 0,0,0, 0,0,           5'b01000));
    tbl.push_back(v(0,0,0,2'b00,0,0,      0,0,0, 0,0,           5'b00000));
    // Contention: byte store first, then the fetch
    tbl.push_back(v(0,1,1,2'b00,32'h200,32'h55, 1,0,32'h100, 0,0,           5'b00011));
    tbl.push_back(v(0,1,1,2'b00,32'h200,32'h55, 1,0,32'h100, 0,0,           5'b10011));
    tbl.push_back(v(0,1,1,2'b00,32'h200,32'h55, 1,0,32'h100, 1,32'h0,       5'b10011));
    tbl.push_back(v(0,1,1,2'b00,32'h200,32'h55, 1,0,32'h100, 0,0,           5'b01001));
    tbl.push_back(v(0,0,0,2'b00,0,0,            1,0,32'h100, 0,0,           5'b00001));
    tbl.push_back(v(0,0,0,2'b00,0,0,            1,0,32'h100, 0,0,           5'b10001));
    tbl.push_back(v(0,0,0,2'b00,0,0,            1,0,32'h100, 1,32'hE3A00001,5'b10001));
    tbl.push_back(v(0,0,0,2'b00,0,0,            1,0,32'h100, 0,0,           5'b00100));
    tbl.push_back(v(0,0,0,2'b00,0,0,            0,0,0,       0,0,           5'b00000));
    // Flushed fetch, then a fresh fetch granted from IDLE
    tbl.push_back(v(0,0,0,0,0,0, 1,0,32'h8, 0,0,           5'b00001));
    tbl.push_back(v(0,0,0,0,0,0, 1,0,32'h8, 0,0,           5'b10001));
    tbl.push_back(v(0,0,0,0,0,0, 1,1,32'h8, 0,0,           5'b10000));
    tbl.push_back(v(0,0,0,0,0,0, 1,0,32'h8, 1,32'h1234,    5'b10001));
    tbl.push_back(v(0,0,0,0,0,0, 1,0,32'h8, 0,0,           5'b00001));
    tbl.push_back(v(0,0,0,0,0,0, 1,0,32'hC, 0,0,           5'b00001));
    tbl.push_back(v(0,0,0,0,0,0, 1,0,32'hC, 1,32'hABCD,    5'b10001));
    tbl.push_back(v(0,0,0,0,0,0, 1,0,32'hC, 0,0,           5'b00100));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0,     0,0,           5'b00000));
    // Timeout: no ack at all
    tbl.push_back(v(0,1,0,2'b10,32'h300,0, 0,0,0, 0,0, 5'b00011));
    for (int i = 0; i < TO; i++)
      tbl.push_back(v(0,1,0,2'b10,32'h300,0, 0,0,0, 0,0, 5'b10011));
    tbl.push_back(v(0,1,0,2'b10,32'h300,0, 0,0,0, 0,0, 5'b01000));
    tbl.push_back(v(0,0,0,2'b00,0,0,       0,0,0, 0,0, 5'b00000));
    // Reset in the middle of a MEM access; the late ack is ignored
    tbl.push_back(v(0,1,0,2'b10,32'h400,0, 0,0,0, 0,0,        5'b00011));
    tbl.push_back(v(0,1,0,2'b10,32'h400,0, 0,0,0, 0,0,        5'b10011));
    tbl.push_back(v(0,1,0,2'b10,32'h400,0, 0,0,0, 0,0,        5'b10011));
    tbl.push_back(v(1,1,0,2'b10,32'h400,0, 0,0,0, 0,0,        5'b10011));
    tbl.push_back(v(0,0,0,2'b00,0,0,       0,0,0, 1,32'hFFFF, 5'b00000));
    tbl.push_back(v(0,0,0,2'b00,0,0,       0,0,0, 0,0,        5'b00000));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1);

    for (int i = 0; i < 3000; i++) begin
      r.rst   = ($urandom_range(0, 199) == 0);
      r.mreq  = ($urandom_range(0, 9) < 3);
      r.mrw   = $urandom_range(0, 1);
      r.msz   = 2'($urandom_range(0, 2));
      r.maddr = $urandom;
      r.mwd   = $urandom;
      r.ireq  = ($urandom_range(0, 9) < 6);
      r.ifl   = ($urandom_range(0, 9) == 0);
      r.iaddr = $urandom;
      r.ack   = ($urandom_range(0, 9) < 3);
      r.rd    = $urandom;
      r.exp   = 5'b0;
      step(r, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
